uart_tx_fifo: RTL and testbench

Parametrised, buffered asynchronous serial transmitter: the next generation of the team's FIFO → controller → transmitter chain, merged into one block. Accepts words on a write port into an internal FIFO and serialises each as start bit, LSB-first data, optional parity and one or two stop bits. Data width, FIFO depth and divider width are compile-time parameters. Bit period, parity mode and stop count are run-time inputs. Adds full/empty/count/overflow status and a busy flag.

---
 rtl/serial_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 83 ++++++++
 rtl/uart_tx_fifo.sv | 158 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the buffered serial transmitter: parity encodings,
// transmitter state enum and a frame-length helper.
package serial_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  function automatic logic par_enabled(input logic [1:0] parity);
    return (parity == PAR_EVEN) || (parity == PAR_ODD);
  endfunction

  // Clocks per frame; a divider of 0 behaves as 1.
  function automatic int unsigned frame_len(input int unsigned data_bits,
                                            input logic [1:0]  parity,
                                            input logic        stop2,
                                            input int unsigned div);
    int unsigned d;
    int unsigned p;
    int unsigned s;
    d = (div == 0) ? 1 : div;
    p = par_enabled(parity) ? 1 : 0;
    s = stop2 ? 2 : 1;
    return (1 + data_bits + p + s) * d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, full/empty flags and a one-cycle
// overflow pulse for writes dropped while full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_en,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             full_reg;
  logic             empty_reg;
  logic             overflow_reg;
  logic             do_wr;
  logic             do_rd;

  // Full/empty come from the registered count, so a write at a full FIFO is
  // dropped even when a pop happens on the same edge.
  assign do_wr = wr_en && !full_reg;
  assign do_rd = rd_en && !empty_reg;

  always_comb begin
    count_next = count_reg;
    if (do_wr && !do_rd) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!do_wr && do_rd) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg    <= count_next;
      full_reg     <= (count_next == CNT_W'(DEPTH));
      empty_reg    <= (count_next == '0);
      overflow_reg <= wr_en && full_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Head is read combinationally so a word written on one edge can be
  // popped on the very next edge.
  assign rd_data  = mem[rd_ptr_reg];
  assign count    = count_reg;
  assign full     = full_reg;
  assign empty    = empty_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered asynchronous serial transmitter: FIFO-fed frame FSM producing
// start bit, LSB-first data, optional parity and one or two stop bits.
module uart_tx_fifo
  import serial_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_en,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic                          tx_serial,
  output logic                          tx_busy,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int IDX_W = $clog2(DATA_BITS);

  tx_state_t            state_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] head;
  logic [DIV_W-1:0]     div_m1_reg;
  logic [DIV_W-1:0]     div_m1_in;
  logic [DIV_W-1:0]     cnt_reg;
  logic [IDX_W-1:0]     bit_idx_reg;
  logic                 par_en_reg;
  logic                 par_bit_reg;
  logic                 stop2_reg;
  logic                 stop_idx_reg;
  logic                 tx_reg;
  logic                 busy_reg;
  logic                 bit_end;
  logic                 last_stop;
  logic                 pop;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_en    (pop),
    .rd_data  (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

  assign div_m1_in = (cfg_div == '0) ? '0 : cfg_div - DIV_W'(1);
  assign bit_end   = (cnt_reg == div_m1_reg);
  assign last_stop = !stop2_reg || stop_idx_reg;

  // Popping on the final stop clock starts the next frame with no idle gap.
  assign pop = !fifo_empty &&
               ((state_reg == IDLE) || (state_reg == STOP && bit_end && last_stop));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      div_m1_reg   <= '0;
      cnt_reg      <= '0;
      bit_idx_reg  <= '0;
      par_en_reg   <= 1'b0;
      par_bit_reg  <= 1'b0;
      stop2_reg    <= 1'b0;
      stop_idx_reg <= 1'b0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      cnt_reg <= bit_end ? '0 : cnt_reg + DIV_W'(1);
      case (state_reg)
        IDLE: begin
          tx_reg   <= 1'b1;
          busy_reg <= 1'b0;
          cnt_reg  <= '0;
        end
        START: begin
          if (bit_end) begin
            state_reg   <= DATA;
            bit_idx_reg <= '0;
            tx_reg      <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx_reg == IDX_W'(DATA_BITS - 1)) begin
              if (par_en_reg) begin
                state_reg <= PARITY;
                tx_reg    <= par_bit_reg;
              end else begin
                state_reg    <= STOP;
                tx_reg       <= 1'b1;
                stop_idx_reg <= 1'b0;
              end
            end else begin
              bit_idx_reg <= bit_idx_reg + IDX_W'(1);
              shift_reg   <= shift_reg >> 1;
              tx_reg      <= shift_reg[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_reg    <= STOP;
            tx_reg       <= 1'b1;
            stop_idx_reg <= 1'b0;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              state_reg <= IDLE;
              tx_reg    <= 1'b1;
              busy_reg  <= 1'b0;
            end else begin
              stop_idx_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase

      // Loading a new frame overrides whatever the state branch scheduled;
      // configuration is captured here and held for the whole frame.
      if (pop) begin
        state_reg   <= START;
        shift_reg   <= head;
        div_m1_reg  <= div_m1_in;
        par_en_reg  <= par_enabled(cfg_parity);
        par_bit_reg <= (^head) ^ (cfg_parity == PAR_ODD);
        stop2_reg   <= cfg_stop2;
        tx_reg      <= 1'b0;
        busy_reg    <= 1'b1;
        cnt_reg     <= '0;
      end
    end
  end

  assign tx_serial = tx_reg;
  assign tx_busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo: serial waveforms are checked
// sample-by-sample against hand-written bit patterns.
module tb_uart_tx_fifo;
  import serial_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  wr_data = '0;
  logic        wr_en = 1'b0;
  logic [15:0] cfg_div = 16'd4;
  logic [1:0]  cfg_parity = PAR_NONE;
  logic        cfg_stop2 = 1'b0;
  logic        tx_serial;
  logic        tx_busy;
  logic        fifo_full;
  logic        fifo_empty;
  logic [3:0]  fifo_count;
  logic        overflow;

  int passed = 0;
  int total = 0;
  int stream_err = 0;
  bit sampling = 1'b0;
  bit exp_q[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DATA_BITS  (8),
    .FIFO_DEPTH (8),
    .DIV_W      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .cfg_div    (cfg_div),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .tx_serial  (tx_serial),
    .tx_busy    (tx_busy),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock: compare the current line sample if a frame is expected, then drive.
  task automatic step(input logic we, input logic [7:0] d);
    if (sampling) begin
      if (exp_q.size() == 0) begin
        stream_err++;
      end else begin
        bit e;
        e = exp_q.pop_front();
        if (tx_serial !== e) stream_err++;
      end
    end
    wr_en   = we;
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (we) $display("write 0x%02h -> count=%0d full=%0b overflow=%0b", d, fifo_count, fifo_full, overflow);
  endtask

  task automatic push_pattern(input string s, input int div);
    for (int i = 0; i < s.len(); i++) begin
      for (int k = 0; k < div; k++) exp_q.push_back(s[i] == 8'h31);
    end
  endtask

  task automatic push_frame(input logic [7:0] w, input int div, input logic [1:0] par, input logic stop2);
    string s;
    s = "0";
    for (int i = 0; i < 8; i++) s = {s, w[i] ? "1" : "0"};
    if (par == PAR_EVEN) s = {s, (^w) ? "1" : "0"};
    if (par == PAR_ODD)  s = {s, (^w) ? "0" : "1"};
    s = {s, stop2 ? "11" : "1"};
    push_pattern(s, (div == 0) ? 1 : div);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    sampling = 1'b1;
    while (exp_q.size() > 0 && guard < 3000) begin
      step(1'b0, 8'h00);
      guard++;
    end
    sampling = 1'b0;
    $display("frame stream %s: %0d bad samples, %0d unsent", tag, stream_err, exp_q.size());
    check({tag, "_stream"}, stream_err, 0);
    check({tag, "_unsent"}, exp_q.size(), 0);
    stream_err = 0;
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lows;
    int busys;

    // Reset and quiet idle line
    rst = 1'b1;
    tick(); tick(); tick();
    check("rst_tx", tx_serial, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0) lows++;
      tick();
    end
    check("idle_quiet", lows, 0);

    // div=4, no parity, 1 stop, 0xA5; config changes mid-frame must not matter
    cfg_div = 16'd4; cfg_parity = PAR_NONE; cfg_stop2 = 1'b0;
    step(1'b1, 8'hA5);
    check("a5_empty_after_write", fifo_empty, 0);
    check("a5_count_after_write", fifo_count, 1);
    check("a5_tx_before_pop", tx_serial, 1);
    step(1'b0, 8'h00);
    check("a5_count_after_pop", fifo_count, 0);
    check("a5_busy", tx_busy, 1);
    cfg_div = 16'd7; cfg_parity = PAR_EVEN; cfg_stop2 = 1'b1;
    push_pattern("0101001011", 4);
    drain("a5_div4");
    check("a5_idle_busy", tx_busy, 0);
    check("a5_idle_tx", tx_serial, 1);

    // div=3 even parity, 0x07 -> parity bit 1
    cfg_div = 16'd3; cfg_parity = PAR_EVEN; cfg_stop2 = 1'b0;
    step(1'b1, 8'h07);
    step(1'b0, 8'h00);
    push_pattern("01110000011", 3);
    drain("even_07");

    // odd parity, two stop bits, 0x07 then 0x00 back-to-back
    cfg_parity = PAR_ODD; cfg_stop2 = 1'b1;
    step(1'b1, 8'h07);
    step(1'b1, 8'h00);
    push_pattern("011100000011", 3);
    push_pattern("000000000111", 3);
    drain("odd_stop2");
    check("odd_idle_busy", tx_busy, 0);

    // Overflow: 9 writes while busy, depth 8
    cfg_div = 16'd2; cfg_parity = PAR_NONE; cfg_stop2 = 1'b0;
    step(1'b1, 8'h3C);
    step(1'b0, 8'h00);
    sampling = 1'b1;
    push_frame(8'h3C, 2, PAR_NONE, 1'b0);
    for (int i = 0; i < 8; i++) push_frame(8'h10 + 8'(i), 2, PAR_NONE, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, (i < 8) ? 8'h10 + 8'(i) : 8'hEE);
      check($sformatf("ovf_count_%0d", i), fifo_count, (i < 8) ? i + 1 : 8);
      check($sformatf("ovf_pulse_%0d", i), overflow, (i == 8) ? 1 : 0);
    end
    check("ovf_full", fifo_full, 1);
    step(1'b0, 8'h00);
    check("ovf_pulse_end", overflow, 0);
    check("ovf_count_hold", fifo_count, 8);
    drain("ovf_frames");
    check("ovf_drained_empty", fifo_empty, 1);

    // Simultaneous write/pop at count 3, then write while full at a pop; div 0 acts as 1
    cfg_div = 16'd0;
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    sampling = 1'b1;
    push_frame(8'h01, 1, PAR_NONE, 1'b0);
    push_frame(8'h02, 1, PAR_NONE, 1'b0);
    step(1'b1, 8'h03);
    step(1'b1, 8'h04);
    check("wp_count3", fifo_count, 3);
    push_frame(8'h03, 1, PAR_NONE, 1'b0);
    push_frame(8'h04, 1, PAR_NONE, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00);
    step(1'b1, 8'h05);
    check("wp_count_same", fifo_count, 3);
    push_frame(8'h05, 1, PAR_NONE, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h06 + 8'(i));
      push_frame(8'h06 + 8'(i), 1, PAR_NONE, 1'b0);
    end
    check("wp_full_count", fifo_count, 8);
    check("wp_full_flag", fifo_full, 1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00);
    step(1'b1, 8'hFF);
    check("wp_full_pop_ovf", overflow, 1);
    check("wp_full_pop_count", fifo_count, 7);
    check("wp_full_pop_flag", fifo_full, 0);
    step(1'b0, 8'h00);
    check("wp_ovf_end", overflow, 0);
    drain("wp_frames");

    // Reset in the middle of DATA with 3 words queued
    cfg_div = 16'd4;
    step(1'b1, 8'h00);
    step(1'b1, 8'hAA);
    step(1'b1, 8'hBB);
    step(1'b1, 8'hCC);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00);
    check("mid_busy", tx_busy, 1);
    check("mid_count", fifo_count, 3);
    check("mid_tx_low", tx_serial, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_tx", tx_serial, 1);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_empty", fifo_empty, 1);
    check("mid_rst_busy", tx_busy, 0);
    lows = 0;
    busys = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx_serial !== 1'b1) lows++;
      if (tx_busy !== 1'b0) busys++;
      tick();
    end
    check("post_rst_quiet", lows, 0);
    check("post_rst_notbusy", busys, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
